pwl_slicer_deser: RTL
=====================

# pwl_slicer_deser

Receive-side counterpart of the bit-to-PWL driver. It samples a `pwl` analog waveform on each clock edge and slices it to a bit with hysteresis. It then deserializes the bit stream MSB-first into W-bit words and aligns to a periodic sync word with a HUNT/CHECK/LOCK framer. It sits after the CTLE/channel models in mLingua link benches and converts the equalized waveform back to payload words.

## Interface
- `vth`, 0.0, slicer threshold (V).
- `vhys`, 0.01, total hysteresis width (V), centered on `vth`.
- `W`, 8, bits per word.
- `SYNC`, 8'hA5, sync word (W bits).
- `FRAME`, 4, words per frame; word 0 is the sync word, words 1..FRAME-1 are payload.
- `LOCK_N`, 3, consecutive correct sync words required to lock (first detection counts as 1).
- `MISS_N`, 2, consecutive sync mismatches while locked before dropping to HUNT.
- Clock and reset: single clock `clk`; reset `rstn` is asynchronous, active-low.
- `clk` input 1: sampling clock, one bit per rising edge.
- `rstn` input 1: async active-low reset.
- `in` input pwl: equalized analog waveform.
- `bit_out` output 1: sliced bit.
- `word` output W: last payload word, MSB = first bit received.
- `word_valid` output 1: one-cycle pulse when `word` updates.
- `locked` output 1: framer in LOCK.
- `sync_err` output 16: saturating count of sync mismatches seen in LOCK.

## Operation
- Slicer: at each rising `clk`, evaluate `in` at the current simulation time using the `PWLMethod` eval at `get_time`. Call that value v.
  - If the previous bit is 0, the new bit is 1 when v > vth+vhys/2; otherwise it stays 0.
  - If the previous bit is 1, the new bit is 0 when v < vth−vhys/2; otherwise it stays 1.
  - Equality holds the previous bit.
- Shift register: `sr_next = {sr[W-2:0], b}`, where b is the new bit. All comparisons use `sr_next`, the window that includes the current bit.
- Counters:
  - `bit_idx` runs 0..W-1. A word boundary is the edge where `bit_idx==W-1`.
  - `word_idx` runs 0..FRAME-1 and increments modulo FRAME at each boundary.
  - A boundary with `word_idx==0` is a sync boundary; all other boundaries are payload boundaries.
- HUNT:
  - Compare `sr_next==SYNC` on every edge.
  - On a match: set `bit_idx=0` and `word_idx=1` (next word is payload 1), set `match_cnt=1`, go to CHECK.
  - If LOCK_N==1, a match goes directly to LOCK.
- CHECK:
  - Only sync boundaries are evaluated; payload is discarded and `word_valid` stays 0.
  - Sync match: increment `match_cnt`; when it reaches LOCK_N, go to LOCK.
  - Sync mismatch: go to HUNT and clear all counters.
- LOCK:
  - Payload boundary: `word <= sr_next` and pulse `word_valid`.
  - Sync boundary, match: `miss_cnt=0`.
  - Sync boundary, mismatch: increment `miss_cnt` and `sync_err` (saturating at 16'hFFFF).
  - When `miss_cnt` reaches MISS_N, go to HUNT. Payload between misses is still delivered.
- `sync_err` is cleared only by reset.

## Timing
- Reset (`rstn`=0, async) forces the following immediately, including mid-frame:
  - `bit_out`=0, `word`=0, `word_valid`=0, `locked`=0, `sync_err`=0.
  - `sr`=0, state=HUNT, all counters=0.
- The first sample is taken at the first rising `clk` after `rstn` rises.
- `bit_out` is registered on the edge where it was sampled, giving 1 edge of latency from sample to output.
- `word_valid` and `word` update on the same edge as the last bit of the payload word. `word_valid` is high for exactly one cycle per payload word.
- `word` holds its value between pulses.
- `locked` rises on the edge of the LOCK_N-th matching sync boundary. With defaults, the first `word_valid` follows 8 edges later.
- `locked` falls on the edge of the MISS_N-th consecutive mismatch. HUNT begins searching on the next edge.
- No `word_valid` is issued on the edge where LOCK is entered or exited.

## Test plan
- **Reset values:** assert `rstn` low mid-frame while locked → all outputs read 0 at once. After release, the block relocks only after 3 fresh sync words.
- **Hysteresis:** vth=0, vhys=0.02, input ramps −0.09→+0.009→+0.011→−0.009→−0.011 V on successive samples → `bit_out` = 0,0,1,1,0.
- **Lock acquisition:** bit2pwl stream (±0.09 V) of frames A5,11,22,33 repeated, `clk` sampling mid-bit → `locked` rises at the end of the third A5. Then `word_valid` pulses with `word` = 11, 22, 33 at 8-edge spacing, and no pulse at A5.
- **False sync in CHECK:** A5 appears once inside payload before the real frames, then a non-A5 word at the expected sync slot → return to HUNT, no `word_valid`. Lock then follows on the real frames.
- **Loss of lock:** while locked, corrupt one sync word to A4 → `sync_err`=1, `locked` stays 1, payload still delivered. Corrupt two consecutive sync words → `sync_err`=3 and `locked` falls at the second bad sync boundary.
- **CTLE path:** drive the stream through the ctle model (gdc=1, fp1=1.2 GHz, fp2=3.4 GHz, fz1=0.55 GHz) at a 1 Gb/s bit rate → lock within 3 frames, with zero `sync_err` over 1000 frames.

Source files
------------

// File: rtl/pwl_slicer_deser.sv
// Hysteresis slicer + MSB-first deserializer + HUNT/CHECK/LOCK frame aligner.
// `in` is the sampled waveform as signed fixed point, 0.1 mV per LSB; VTH/VHYS use the same scale.
//
//   state | meaning
//   HUNT  | sliding search for SYNC on every edge, counters held at 0
//   CHECK | aligned, confirming SYNC at each sync boundary, payload dropped
//   LOCK  | aligned, payload words delivered, sync misses counted
module pwl_slicer_deser #(
    parameter int           VTH    = 0,
    parameter int           VHYS   = 100,
    parameter int           W      = 8,
    parameter logic [W-1:0] SYNC   = 8'hA5,
    parameter int           FRAME  = 4,
    parameter int           LOCK_N = 3,
    parameter int           MISS_N = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic signed [15:0]  in,
    output logic                bit_out,
    output logic [W-1:0]        word,
    output logic                word_valid,
    output logic                locked,
    output logic [15:0]         sync_err
);

    localparam int BI_W = (W > 1) ? $clog2(W) : 1;
    localparam int WI_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int MC_W = $clog2(LOCK_N + 1);
    localparam int MS_W = $clog2(MISS_N + 1);

    localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(W - 1);
    localparam logic [WI_W-1:0] WORD_LAST = WI_W'(FRAME - 1);
    localparam logic [WI_W-1:0] WORD_ONE  = WI_W'(1);
    localparam logic [MC_W-1:0] LOCK_CNT  = MC_W'(LOCK_N);
    localparam logic [MC_W-1:0] MATCH_ONE = MC_W'(1);
    localparam logic [MS_W-1:0] MISS_CNT  = MS_W'(MISS_N);

    // Thresholds kept doubled so an odd VHYS splits exactly around VTH.
    localparam logic signed [17:0] THR_HI = 18'(2 * VTH + VHYS);
    localparam logic signed [17:0] THR_LO = 18'(2 * VTH - VHYS);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    sr;
    logic [BI_W-1:0] bit_idx, bit_idx_nxt;
    logic [WI_W-1:0] word_idx, word_idx_nxt;
    logic [MC_W-1:0] match_cnt, match_nxt, match_inc;
    logic [MS_W-1:0] miss_cnt, miss_nxt, miss_inc;
    logic [W-1:0]    word_nxt;
    logic            word_valid_nxt;
    logic [15:0]     sync_err_nxt;

    logic signed [17:0] v2;
    logic               b;
    logic [W-1:0]       sr_next;
    logic               boundary, sync_slot, sync_ok;
    logic [BI_W-1:0]    bit_idx_inc;
    logic [WI_W-1:0]    word_idx_inc;

    assign v2        = {in[15], in, 1'b0};
    assign b         = bit_out ? (v2 >= THR_LO) : (v2 > THR_HI);
    assign sr_next   = {sr[W-2:0], b};
    assign boundary  = (bit_idx == BIT_LAST);
    assign sync_slot = (word_idx == '0);
    assign sync_ok   = (sr_next == SYNC);
    assign match_inc = match_cnt + 1'b1;
    assign miss_inc  = miss_cnt + 1'b1;

    assign bit_idx_inc  = boundary ? '0 : bit_idx + 1'b1;
    assign word_idx_inc = !boundary ? word_idx :
                          (word_idx == WORD_LAST) ? '0 : word_idx + 1'b1;

    assign locked = (state == LOCK);

    always_comb begin
        state_nxt      = state;
        bit_idx_nxt    = bit_idx_inc;
        word_idx_nxt   = word_idx_inc;
        match_nxt      = match_cnt;
        miss_nxt       = miss_cnt;
        word_nxt       = word;
        word_valid_nxt = 1'b0;
        sync_err_nxt   = sync_err;

        case (state)
            HUNT: begin
                bit_idx_nxt  = '0;
                word_idx_nxt = '0;
                match_nxt    = '0;
                miss_nxt     = '0;
                if (sync_ok) begin
                    word_idx_nxt = WORD_ONE;
                    match_nxt    = MATCH_ONE;
                    state_nxt    = (LOCK_N <= 1) ? LOCK : CHECK;
                end
            end

            CHECK: begin
                if (boundary && sync_slot) begin
                    if (sync_ok) begin
                        match_nxt = match_inc;
                        if (match_inc == LOCK_CNT) begin
                            state_nxt = LOCK;
                        end
                    end else begin
                        state_nxt    = HUNT;
                        bit_idx_nxt  = '0;
                        word_idx_nxt = '0;
                        match_nxt    = '0;
                    end
                end
            end

            LOCK: begin
                if (boundary && sync_slot) begin
                    if (sync_ok) begin
                        miss_nxt = '0;
                    end else begin
                        miss_nxt = miss_inc;
                        if (sync_err != '1) begin
                            sync_err_nxt = sync_err + 1'b1;
                        end
                        if (miss_inc == MISS_CNT) begin
                            state_nxt    = HUNT;
                            bit_idx_nxt  = '0;
                            word_idx_nxt = '0;
                            match_nxt    = '0;
                            miss_nxt     = '0;
                        end
                    end
                end else if (boundary) begin
                    word_nxt       = sr_next;
                    word_valid_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt    = HUNT;
                bit_idx_nxt  = '0;
                word_idx_nxt = '0;
                match_nxt    = '0;
                miss_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= HUNT;
            bit_out    <= 1'b0;
            sr         <= '0;
            bit_idx    <= '0;
            word_idx   <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            sync_err   <= '0;
        end else begin
            state      <= state_nxt;
            bit_out    <= b;
            sr         <= sr_next;
            bit_idx    <= bit_idx_nxt;
            word_idx   <= word_idx_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            word       <= word_nxt;
            word_valid <= word_valid_nxt;
            sync_err   <= sync_err_nxt;
        end
    end

endmodule
